// File: rtl/if_stage_fq_pkg.sv
// rtl/if_stage_fq_pkg.sv - shared constants, fetch entry payload type and address-map helper for if_stage_fq
package if_stage_fq_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;
   localparam logic [7:0]  EXC_ADEL     = 8'h04;

   // Top three VA bits of the unmapped segments; both translate by clearing them.
   localparam logic [2:0]  KSEG0_TAG    = 3'b100;
   localparam logic [2:0]  KSEG1_TAG    = 3'b101;

   // The PC is carried beside this payload because its width follows AW.
   typedef struct packed {
      logic [31:0] inst;
      logic        exc;
      logic [7:0]  exccode;
   } fetch_info_t;

   localparam int INFO_W = $bits(fetch_info_t);

   function automatic logic is_unmapped(input logic [2:0] tag);
      return (tag == KSEG0_TAG) || (tag == KSEG1_TAG);
   endfunction

endpackage

// File: rtl/if_stage_fq_if.sv
// rtl/if_stage_fq_if.sv - fetch-to-decode handshake and inst SRAM port bundle for if_stage_fq
interface if_stage_fq_if #(
   parameter int AW = 32
);
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          ds_allowin;
   logic          fs_to_ds_valid;
   logic [AW-1:0] fs_pc;
   logic [31:0]   fs_inst;
   logic          fs_exc;
   logic [7:0]    fs_exccode;
   logic          inst_sram_en;
   logic [3:0]    inst_sram_wen;
   logic [AW-1:0] inst_sram_addr;
   logic [31:0]   inst_sram_wdata;
   logic [31:0]   inst_sram_rdata;

   modport master (
      input  redirect_valid, redirect_pc, ds_allowin, inst_sram_rdata,
      output fs_to_ds_valid, fs_pc, fs_inst, fs_exc, fs_exccode,
      output inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
   );

   modport slave (
      output redirect_valid, redirect_pc, ds_allowin, inst_sram_rdata,
      input  fs_to_ds_valid, fs_pc, fs_inst, fs_exc, fs_exccode,
      input  inst_sram_en, inst_sram_wen, inst_sram_addr, inst_sram_wdata
   );

endinterface

// File: rtl/if_stage_fq_fetch_fifo.sv
// rtl/if_stage_fq_fetch_fifo.sv - DEPTH-entry fetch queue with push/pop/flush, occupancy count and head data
module if_stage_fq_fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   input  logic                     push,
   input  logic [W-1:0]             push_data,
   input  logic                     pop,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [W-1:0]             head
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          full;
   logic          do_pop;
   logic          do_push;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   // At full a push only lands when the head leaves in the same cycle.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/if_stage_fq.sv
// rtl/if_stage_fq.sv - instruction fetch stage: sequential PC, credit-gated SRAM reads, fetch queue to decode.
// Optional perf counters are built when IF_STAGE_PERF_EN is defined.
module if_stage_fq
   import if_stage_fq_pkg::*;
#(
   parameter int            AW       = 32,
   parameter int            DEPTH    = 4,
   parameter logic [AW-1:0] RESET_PC = AW'(RESET_PC_DEF)
) (
   input  logic          clk,
   input  logic          rst_n,
   if_stage_fq_if.master bus
`ifdef IF_STAGE_PERF_EN
   ,
   output logic [31:0]   perf_stall_cnt,
   output logic [31:0]   perf_flush_cnt
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = AW + INFO_W;

   logic [AW-1:0] pc_req;
   logic [AW-1:0] pend_pc;
   logic          inflight;
   logic          exc_pend;
   logic          halted;

   logic          redirect;
   logic [AW-1:0] iss_va;
   logic [AW-1:0] iss_pa;
   logic          aligned;
   logic          halted_eff;
   logic [CW:0]   demand;
   logic          credit_ok;
   logic          issue;
   logic          misalign_take;

   logic          fifo_push;
   logic          fifo_pop;
   logic          fifo_empty;
   logic [CW-1:0] occ;
   fetch_info_t   push_info;
   logic [EW-1:0] push_data;
   logic [EW-1:0] head;
   logic [AW-1:0] head_pc;
   fetch_info_t   head_info;
   logic          fs_valid;

   assign redirect = bus.redirect_valid;
   assign iss_va   = redirect ? bus.redirect_pc : pc_req;
   assign aligned  = (iss_va[1:0] == 2'b00);

   always_comb begin
      iss_pa = iss_va;
      if (is_unmapped(iss_va[31:29])) begin
         iss_pa[31:29] = 3'b000;
      end
   end

   // A redirect discards everything outstanding, so it always sees full credit.
   assign halted_eff = halted && !redirect;
   assign demand     = redirect ? '0
                                : ((CW+1)'(occ) + (CW+1)'(inflight) + (CW+1)'(exc_pend));
   assign credit_ok  = (demand < (CW+1)'(DEPTH));

   assign issue         = !halted_eff && aligned && credit_ok;
   assign misalign_take = !halted_eff && !aligned && credit_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_req   <= RESET_PC;
         pend_pc  <= '0;
         inflight <= 1'b0;
         exc_pend <= 1'b0;
         halted   <= 1'b0;
      end else begin
         inflight <= issue;
         exc_pend <= misalign_take;
         if (issue) begin
            pc_req  <= iss_va + AW'(4);
            pend_pc <= iss_va;
         end else if (misalign_take) begin
            pend_pc <= iss_va;
         end
         if (misalign_take) begin
            halted <= 1'b1;
         end else if (redirect) begin
            halted <= 1'b0;
         end
      end
   end

   // Response and exception never coincide: a misaligned cycle issues nothing.
   always_comb begin
      push_info.inst    = bus.inst_sram_rdata;
      push_info.exc     = 1'b0;
      push_info.exccode = 8'h00;
      if (exc_pend) begin
         push_info.inst    = 32'h0;
         push_info.exc     = 1'b1;
         push_info.exccode = EXC_ADEL;
      end
   end

   assign fifo_push = (inflight || exc_pend) && !redirect;
   assign push_data = {pend_pc, push_info};
   assign fs_valid  = !fifo_empty && !redirect;
   assign fifo_pop  = fs_valid && bus.ds_allowin;

   if_stage_fq_fetch_fifo #(
      .DEPTH (DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (redirect),
      .push      (fifo_push),
      .push_data (push_data),
      .pop       (fifo_pop),
      .empty     (fifo_empty),
      .count     (occ),
      .head      (head)
   );

   assign {head_pc, head_info} = head;

   assign bus.fs_to_ds_valid  = fs_valid;
   assign bus.fs_pc           = head_pc;
   assign bus.fs_inst         = head_info.inst;
   assign bus.fs_exc          = head_info.exc;
   assign bus.fs_exccode      = head_info.exccode;

   assign bus.inst_sram_en    = issue && rst_n;
   assign bus.inst_sram_wen   = 4'b0000;
   assign bus.inst_sram_addr  = iss_pa;
   assign bus.inst_sram_wdata = 32'h0;

`ifdef IF_STAGE_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (fs_valid && !bus.ds_allowin) begin
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         end
         if (redirect && ((occ != '0) || inflight || exc_pend)) begin
            perf_flush_cnt <= perf_flush_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_if_stage_fq.sv
// tb/tb_if_stage_fq.sv - self-checking bench for if_stage_fq with a sequential-PC reference model
module tb_if_stage_fq;

   localparam int DEPTH = 4;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] key;
   int          n_checks     = 0;
   int          n_fail       = 0;
   int          overflow_cnt = 0;

   if_stage_fq_if #(.AW(32)) bus ();

`ifdef IF_STAGE_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;
`endif

   if_stage_fq #(
      .AW       (32),
      .DEPTH    (DEPTH),
      .RESET_PC (32'hBFC0_0000)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.master)
`ifdef IF_STAGE_PERF_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Synchronous SRAM: data returned is the physical address scrambled by a per-run key.
   always @(posedge clk) begin
      if (bus.inst_sram_en) bus.inst_sram_rdata <= bus.inst_sram_addr ^ key;
   end

   always @(posedge clk) begin
      if (rst_n && dut.u_fifo.push && dut.u_fifo.full && !dut.u_fifo.pop)
         overflow_cnt <= overflow_cnt + 1;
   end

   function automatic logic [31:0] phys(input logic [31:0] va);
      if (va[31:30] == 2'b10) return {3'b000, va[28:0]};
      return va;
   endfunction

   task automatic drive_cycle(input logic allow, input logic rv, input logic [31:0] rpc);
      @(posedge clk);
      #1;
      bus.ds_allowin     = allow;
      bus.redirect_valid = rv;
      bus.redirect_pc    = rpc;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      bus.ds_allowin = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++; if (bus.fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.fs_to_ds_valid); end
      n_checks++; if (bus.fs_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h expected 0", bus.fs_pc); end
      n_checks++; if (bus.fs_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h expected 0", bus.fs_inst); end
      n_checks++; if (bus.fs_exc !== 1'b0 || bus.fs_exccode !== 8'h0) begin n_fail++; $display("FAIL reset_exc: got %b/%h expected 0/00", bus.fs_exc, bus.fs_exccode); end
      n_checks++; if (bus.inst_sram_en !== 1'b0) begin n_fail++; $display("FAIL reset_en: got %b expected 0", bus.inst_sram_en); end
      n_checks++; if (bus.inst_sram_wen !== 4'h0 || bus.inst_sram_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wr: got %h/%h expected 0/0", bus.inst_sram_wen, bus.inst_sram_wdata); end
      rst_n = 1'b1;
      #1;
      n_checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h1FC0_0000) begin n_fail++; $display("FAIL release_first_req: got en=%b addr=%h expected 1/1fc00000", bus.inst_sram_en, bus.inst_sram_addr); end
   endtask

   task automatic test_stream;
      logic [31:0] exp_addr, exp_pc;
      for (int k = 0; k < 12; k++) begin
         drive_cycle(1'b1, 1'b0, 32'h0);
         exp_addr = phys(32'hBFC0_0000 + 32'(4 * (k + 1)));
         n_checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== exp_addr) begin n_fail++; $display("FAIL stream_addr[%0d]: got en=%b addr=%h expected 1/%h", k, bus.inst_sram_en, bus.inst_sram_addr, exp_addr); end
         if (k == 0) begin
            n_checks++; if (bus.fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL stream_first_valid_early: got %b expected 0", bus.fs_to_ds_valid); end
         end else begin
            exp_pc = 32'hBFC0_0000 + 32'(4 * (k - 1));
            n_checks++; if (bus.fs_to_ds_valid !== 1'b1 || bus.fs_pc !== exp_pc || bus.fs_inst !== (phys(exp_pc) ^ key)) begin n_fail++; $display("FAIL stream_out[%0d]: got v=%b pc=%h inst=%h expected 1/%h/%h", k, bus.fs_to_ds_valid, bus.fs_pc, bus.fs_inst, exp_pc, phys(exp_pc) ^ key); end
         end
      end
   endtask

   task automatic test_stall;
      int issued, got;
      logic [31:0] exp_pc;
      issued = 0;
      drive_cycle(1'b0, 1'b1, 32'h8000_0000);
      n_checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h0000_0000) begin n_fail++; $display("FAIL stall_redirect_addr: got en=%b addr=%h expected 1/00000000", bus.inst_sram_en, bus.inst_sram_addr); end
      if (bus.inst_sram_en === 1'b1) issued++;
      for (int k = 0; k < 10; k++) begin
         drive_cycle(1'b0, 1'b0, 32'h0);
         if (bus.inst_sram_en === 1'b1) issued++;
      end
      n_checks++; if (issued != DEPTH) begin n_fail++; $display("FAIL stall_issued: got %0d expected %0d", issued, DEPTH); end
      n_checks++; if (bus.inst_sram_en !== 1'b0) begin n_fail++; $display("FAIL stall_en_idle: got %b expected 0", bus.inst_sram_en); end
      n_checks++; if (bus.fs_to_ds_valid !== 1'b1 || bus.fs_pc !== 32'h8000_0000) begin n_fail++; $display("FAIL stall_head: got v=%b pc=%h expected 1/80000000", bus.fs_to_ds_valid, bus.fs_pc); end
      exp_pc = 32'h8000_0000;
      got = 0;
      for (int k = 0; k < 30 && got < 8; k++) begin
         drive_cycle(1'b1, 1'b0, 32'h0);
         if (bus.fs_to_ds_valid === 1'b1) begin
            n_checks++; if (bus.fs_pc !== exp_pc || bus.fs_inst !== (phys(exp_pc) ^ key)) begin n_fail++; $display("FAIL drain_order[%0d]: got pc=%h inst=%h expected %h/%h", got, bus.fs_pc, bus.fs_inst, exp_pc, phys(exp_pc) ^ key); end
            exp_pc += 32'd4;
            got++;
         end
      end
      n_checks++; if (got != 8) begin n_fail++; $display("FAIL drain_timeout: got %0d entries expected 8", got); end
   endtask

   task automatic test_redirect_flush;
      int got;
      logic [31:0] exp_pc;
      drive_cycle(1'b0, 1'b1, 32'hBFC0_1000);
      repeat (3) drive_cycle(1'b0, 1'b0, 32'h0);
      drive_cycle(1'b1, 1'b1, 32'h8000_0100);
      n_checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h0000_0100) begin n_fail++; $display("FAIL flush_addr: got en=%b addr=%h expected 1/00000100", bus.inst_sram_en, bus.inst_sram_addr); end
      n_checks++; if (bus.fs_to_ds_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid_masked: got %b expected 0", bus.fs_to_ds_valid); end
      exp_pc = 32'h8000_0100;
      got = 0;
      for (int k = 0; k < 30 && got < 6; k++) begin
         drive_cycle(1'b1, 1'b0, 32'h0);
         if (bus.fs_to_ds_valid === 1'b1) begin
            n_checks++; if (bus.fs_pc !== exp_pc || bus.fs_inst !== (phys(exp_pc) ^ key)) begin n_fail++; $display("FAIL flush_order[%0d]: got pc=%h inst=%h expected %h/%h", got, bus.fs_pc, bus.fs_inst, exp_pc, phys(exp_pc) ^ key); end
            exp_pc += 32'd4;
            got++;
         end
      end
      n_checks++; if (got != 6) begin n_fail++; $display("FAIL flush_timeout: got %0d entries expected 6", got); end
   endtask

   task automatic test_misaligned;
      int n_en, n_valid;
      logic seen;
      n_en = 0; n_valid = 0;
      drive_cycle(1'b1, 1'b1, 32'hBFC0_0102);
      n_checks++; if (bus.inst_sram_en !== 1'b0) begin n_fail++; $display("FAIL misalign_no_req: got %b expected 0", bus.inst_sram_en); end
      for (int k = 0; k < 8; k++) begin
         drive_cycle(1'b1, 1'b0, 32'h0);
         if (bus.inst_sram_en === 1'b1) n_en++;
         if (bus.fs_to_ds_valid === 1'b1) begin
            n_valid++;
            n_checks++; if (bus.fs_pc !== 32'hBFC0_0102 || bus.fs_exc !== 1'b1 || bus.fs_exccode !== 8'h04 || bus.fs_inst !== 32'h0) begin n_fail++; $display("FAIL misalign_entry: got pc=%h exc=%b code=%h inst=%h expected bfc00102/1/04/0", bus.fs_pc, bus.fs_exc, bus.fs_exccode, bus.fs_inst); end
         end
      end
      n_checks++; if (n_en != 0) begin n_fail++; $display("FAIL misalign_halted: got %0d requests expected 0", n_en); end
      n_checks++; if (n_valid != 1) begin n_fail++; $display("FAIL misalign_count: got %0d entries expected 1", n_valid); end
      drive_cycle(1'b1, 1'b1, 32'hBFC0_0200);
      n_checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h1FC0_0200) begin n_fail++; $display("FAIL resume_addr: got en=%b addr=%h expected 1/1fc00200", bus.inst_sram_en, bus.inst_sram_addr); end
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
         drive_cycle(1'b1, 1'b0, 32'h0);
         if (bus.fs_to_ds_valid === 1'b1) begin
            seen = 1'b1;
            n_checks++; if (bus.fs_pc !== 32'hBFC0_0200 || bus.fs_exc !== 1'b0) begin n_fail++; $display("FAIL resume_entry: got pc=%h exc=%b expected bfc00200/0", bus.fs_pc, bus.fs_exc); end
         end
      end
      n_checks++; if (!seen) begin n_fail++; $display("FAIL resume_timeout: got no entry expected bfc00200"); end
   endtask

   task automatic test_random;
      logic [31:0] exp_iss, exp_del, rpc, tmp;
      logic allow, rv;
      drive_cycle(1'b1, 1'b1, 32'h8000_4000);
      exp_iss = 32'h8000_4004;
      exp_del = 32'h8000_4000;
      for (int k = 0; k < 500; k++) begin
         allow = ($urandom_range(0, 3) != 0);
         rv    = ($urandom_range(0, 15) == 0);
         tmp   = $urandom;
         case ($urandom_range(0, 2))
            0:       rpc = {3'b100, tmp[28:2], 2'b00};
            1:       rpc = {3'b101, tmp[28:2], 2'b00};
            default: rpc = {3'b000, tmp[28:2], 2'b00};
         endcase
         if (k >= 490) begin allow = 1'b1; rv = 1'b0; end
         drive_cycle(allow, rv, rpc);
         if (rv) begin
            n_checks++; if (bus.fs_to_ds_valid !== 1'b0 || bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== phys(rpc)) begin n_fail++; $display("FAIL rand_redirect[%0d]: got v=%b en=%b addr=%h expected 0/1/%h", k, bus.fs_to_ds_valid, bus.inst_sram_en, bus.inst_sram_addr, phys(rpc)); end
            exp_iss = rpc + 32'd4;
            exp_del = rpc;
         end else begin
            if (bus.inst_sram_en === 1'b1) begin
               n_checks++; if (bus.inst_sram_addr !== phys(exp_iss)) begin n_fail++; $display("FAIL rand_issue[%0d]: got %h expected %h", k, bus.inst_sram_addr, phys(exp_iss)); end
               exp_iss += 32'd4;
            end
            if (bus.fs_to_ds_valid === 1'b1 && allow) begin
               n_checks++; if (bus.fs_pc !== exp_del || bus.fs_inst !== (phys(exp_del) ^ key) || bus.fs_exc !== 1'b0) begin n_fail++; $display("FAIL rand_deliver[%0d]: got pc=%h inst=%h exc=%b expected %h/%h/0", k, bus.fs_pc, bus.fs_inst, bus.fs_exc, exp_del, phys(exp_del) ^ key); end
               exp_del += 32'd4;
            end
         end
      end
      n_checks++; if (bus.fs_to_ds_valid !== 1'b1) begin n_fail++; $display("FAIL rand_live: got %b expected 1", bus.fs_to_ds_valid); end
   endtask

   task automatic test_async_reset;
      repeat (3) drive_cycle(1'b1, 1'b0, 32'h0);
      n_checks++; if (bus.fs_to_ds_valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid: got %b expected 1", bus.fs_to_ds_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.fs_to_ds_valid !== 1'b0 || bus.inst_sram_en !== 1'b0) begin n_fail++; $display("FAIL arst_immediate: got v=%b en=%b expected 0/0", bus.fs_to_ds_valid, bus.inst_sram_en); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++; if (bus.inst_sram_en !== 1'b1 || bus.inst_sram_addr !== 32'h1FC0_0000) begin n_fail++; $display("FAIL arst_restart_addr: got en=%b addr=%h expected 1/1fc00000", bus.inst_sram_en, bus.inst_sram_addr); end
      repeat (2) drive_cycle(1'b1, 1'b0, 32'h0);
      n_checks++; if (bus.fs_to_ds_valid !== 1'b1 || bus.fs_pc !== 32'hBFC0_0000) begin n_fail++; $display("FAIL arst_restart_pc: got v=%b pc=%h expected 1/bfc00000", bus.fs_to_ds_valid, bus.fs_pc); end
   endtask

`ifdef IF_STAGE_PERF_EN
   task automatic test_perf;
      drive_cycle(1'b1, 1'b0, 32'h0);
      #2;
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_checks++; if (perf_stall_cnt !== 32'd0 || perf_flush_cnt !== 32'd0) begin n_fail++; $display("FAIL perf_reset: got %0d/%0d expected 0/0", perf_stall_cnt, perf_flush_cnt); end
      repeat (3) drive_cycle(1'b1, 1'b0, 32'h0);
      repeat (5) drive_cycle(1'b0, 1'b0, 32'h0);
      drive_cycle(1'b1, 1'b1, 32'h8000_0000);
      repeat (3) drive_cycle(1'b1, 1'b0, 32'h0);
      drive_cycle(1'b1, 1'b1, 32'hBFC0_0102);
      repeat (4) drive_cycle(1'b1, 1'b0, 32'h0);
      drive_cycle(1'b1, 1'b1, 32'hBFC0_0000);
      repeat (2) drive_cycle(1'b1, 1'b0, 32'h0);
      n_checks++; if (perf_stall_cnt !== 32'd5) begin n_fail++; $display("FAIL perf_stall: got %0d expected 5", perf_stall_cnt); end
      n_checks++; if (perf_flush_cnt !== 32'd2) begin n_fail++; $display("FAIL perf_flush: got %0d expected 2", perf_flush_cnt); end
   endtask
`endif

   task automatic test_overflow;
      n_checks++; if (overflow_cnt != 0) begin n_fail++; $display("FAIL queue_overflow: got %0d pushes at full expected 0", overflow_cnt); end
   endtask

   initial begin
      key = $urandom;
      test_reset();
      test_stream();
      test_stall();
      test_redirect_flush();
      test_misaligned();
      test_random();
      test_async_reset();
`ifdef IF_STAGE_PERF_EN
      test_perf();
`endif
      test_overflow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
